// File: rtl/grayscale.sv
// -----------------------------------------------------------------------------
// grayscale
//
// Pixel-format front end of the edge-detection pipeline. Pops packed RGB
// pixels from a first-word-fall-through input FIFO and converts each one to an
// 8-bit luminance value (R+G+B)/3 in a three-stage stallable pipeline. The
// result is pushed into the FIFO that feeds the sobel stage. Written pixels are
// counted so that each frame boundary can be flagged.
//
// Parameters:
//   DWIDTH_IN   packed input pixel width, must be 3*DWIDTH_OUT
//   DWIDTH_OUT  output luminance width
//   IMG_WIDTH   pixels per line
//   IMG_HEIGHT  lines per frame
//
// Ports:
//   clock           in   single clock, rising edge
//   reset           in   asynchronous, active-low reset
//   fifo_in_rd_en   out  pop request to the input FIFO
//   fifo_in_dout    in   current pixel: R in the top byte, B in the bottom byte
//   fifo_in_empty   in   input FIFO empty
//   fifo_out_wr_en  out  push strobe to the output FIFO
//   fifo_out_din    out  luminance value being pushed
//   fifo_out_full   in   output FIFO full
//   frame_done      out  one-cycle pulse after the last pixel of a frame
//   frame_count     out  completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module grayscale #(
  parameter int DWIDTH_IN  = 24,
  parameter int DWIDTH_OUT = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  fifo_in_rd_en,
  input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                  fifo_in_empty,
  output logic                  fifo_out_wr_en,
  output logic [DWIDTH_OUT-1:0] fifo_out_din,
  input  logic                  fifo_out_full,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  // Two extra bits hold the sum of three channels without overflow.
  localparam int SUM_W = DWIDTH_OUT + 2;
  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [19:0] LAST_PIXEL = 20'(FRAME_PIXELS - 1);

  logic                  adv;
  logic [DWIDTH_OUT-1:0] red;
  logic [DWIDTH_OUT-1:0] green;
  logic [DWIDTH_OUT-1:0] blue;
  logic [SUM_W-1:0]      pixel_sum;
  logic [SUM_W-1:0]      quotient;

  logic                  v1;
  logic [SUM_W-1:0]      sum1;
  logic                  v2;
  logic [DWIDTH_OUT-1:0] q2;
  logic                  ov;
  logic [DWIDTH_OUT-1:0] od;

  logic [19:0]           pix_cnt;

  // The whole pipe moves as one unit; it only stops when the output stage
  // holds a pixel that the full output FIFO cannot accept.
  assign adv = !ov || !fifo_out_full;

  // Reset gates the read strobe because adv alone is high during reset.
  assign fifo_in_rd_en  = reset && !fifo_in_empty && adv;
  assign fifo_out_wr_en = ov && !fifo_out_full;
  assign fifo_out_din   = od;

  assign red   = fifo_in_dout[3*DWIDTH_OUT-1 -: DWIDTH_OUT];
  assign green = fifo_in_dout[2*DWIDTH_OUT-1 -: DWIDTH_OUT];
  assign blue  = fifo_in_dout[DWIDTH_OUT-1 -: DWIDTH_OUT];

  assign pixel_sum = SUM_W'(red) + SUM_W'(green) + SUM_W'(blue);

  // Exact integer division by a constant; the quotient never exceeds the
  // channel maximum, so the upper bits are always zero.
  assign quotient = sum1 / SUM_W'(3);

  // Three-stage datapath. The sum is captured even on bubbles; the valid
  // flags alone decide whether a stage carries a real pixel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1   <= 1'b0;
      sum1 <= '0;
      v2   <= 1'b0;
      q2   <= '0;
      ov   <= 1'b0;
      od   <= '0;
    end else if (adv) begin
      v1   <= fifo_in_rd_en;
      sum1 <= pixel_sum;
      v2   <= v1;
      q2   <= quotient[DWIDTH_OUT-1:0];
      ov   <= v2;
      od   <= q2;
    end
  end

  // Pixel counter and frame bookkeeping. The frame pulse is registered so it
  // appears in the cycle after the write that completes the frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_cnt     <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fifo_out_wr_en) begin
        if (pix_cnt == LAST_PIXEL) begin
          pix_cnt     <= '0;
          frame_count <= frame_count + 16'd1;
          frame_done  <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 20'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_grayscale.sv
// -----------------------------------------------------------------------------
// tb_grayscale
//
// Self-checking bench for grayscale with a 4x2 frame. A queue models the
// first-word-fall-through input FIFO; a scoreboard queue holds the luminance
// expected for every pixel popped and is compared against each write.
// Frame pulses and frame counts come from a simple write-counting model.
// -----------------------------------------------------------------------------
module tb_grayscale;

  localparam int W = 4;
  localparam int H = 2;
  localparam int FRAME = W * H;

  logic        clock;
  logic        reset;
  logic        fifo_in_rd_en;
  logic [23:0] fifo_in_dout;
  logic        fifo_in_empty;
  logic        fifo_out_wr_en;
  logic [7:0]  fifo_out_din;
  logic        fifo_out_full;
  logic        frame_done;
  logic [15:0] frame_count;

  grayscale #(
    .DWIDTH_IN (24),
    .DWIDTH_OUT(8),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .fifo_in_rd_en (fifo_in_rd_en),
    .fifo_in_dout  (fifo_in_dout),
    .fifo_in_empty (fifo_in_empty),
    .fifo_out_wr_en(fifo_out_wr_en),
    .fifo_out_din  (fifo_out_din),
    .fifo_out_full (fifo_out_full),
    .frame_done    (frame_done),
    .frame_count   (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] pix;
    logic [7:0]  lum;
  } vec_t;

  vec_t        vecs[9];

  int          check_count = 0;
  int          pass_count  = 0;

  logic [23:0] in_q[$];
  logic [7:0]  exp_q[$];
  int          rd_cyc_q[$];

  int          cyc = 0;
  int          model_pix = 0;
  logic [15:0] model_frames = 0;
  logic        model_done = 1'b0;
  int          last_lat = 0;
  logic [7:0]  last_din = 0;
  logic        wrote_now = 1'b0;
  int          wr_total = 0;

  logic        rand_mode = 1'b0;
  logic        bp_mode = 1'b0;
  int          bp_writes = 0;
  int          bp_left = 0;

  // Luminance straight from the definition: mean of the three channels.
  function automatic logic [7:0] lum_of(logic [23:0] p);
    int s;
    s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    return 8'(s / 3);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive the inputs for the coming cycle from the FIFO model and the
  // current stall settings.
  task automatic applyStimulus();
    logic hold;
    fifo_out_full = 1'b0;
    if (bp_mode && bp_writes >= 2 && bp_left > 0) begin
      fifo_out_full = 1'b1;
      bp_left--;
    end else if (rand_mode) begin
      fifo_out_full = ($urandom_range(0, 2) == 0);
    end
    hold = rand_mode && ($urandom_range(0, 2) == 0);
    fifo_in_empty = (in_q.size() == 0) || hold;
    fifo_in_dout  = (in_q.size() > 0) ? in_q[0] : 24'($urandom);
  endtask

  // One clock cycle: observe at the falling edge, then redrive after the
  // rising edge.
  task automatic tick();
    logic [7:0] exp_lum;
    @(negedge clock);
    cyc++;
    wrote_now = 1'b0;
    checkOutput("rd_while_empty", 32'(fifo_in_rd_en && fifo_in_empty), 0);
    checkOutput("wr_while_full", 32'(fifo_out_wr_en && fifo_out_full), 0);
    checkOutput("frame_done", 32'(frame_done), 32'(model_done));
    checkOutput("frame_count", 32'(frame_count), 32'(model_frames));
    if (bp_mode && fifo_out_full)
      checkOutput("rd_during_stall", 32'(fifo_in_rd_en), 0);
    if (fifo_in_rd_en) begin
      if (in_q.size() > 0) begin
        exp_q.push_back(lum_of(in_q[0]));
        rd_cyc_q.push_back(cyc);
        void'(in_q.pop_front());
      end else begin
        checkOutput("read_past_end", 1, 0);
      end
    end
    model_done = 1'b0;
    if (fifo_out_wr_en) begin
      wrote_now = 1'b1;
      wr_total++;
      if (bp_mode) bp_writes++;
      last_din = fifo_out_din;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 1, 0);
      end else begin
        exp_lum  = exp_q.pop_front();
        last_lat = cyc - rd_cyc_q.pop_front();
        checkOutput("write_data", 32'(fifo_out_din), 32'(exp_lum));
      end
      model_pix++;
      if (model_pix == FRAME) begin
        model_pix = 0;
        model_frames++;
        model_done = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    applyStimulus();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < 300) begin
      tick();
      n++;
    end
    checkOutput("drain_timeout", 32'(in_q.size() + exp_q.size()), 0);
  endtask

  task automatic clearModel();
    exp_q.delete();
    rd_cyc_q.delete();
    model_pix    = 0;
    model_frames = 0;
    model_done   = 1'b0;
  endtask

  // Short reset pulse taken from just after a rising edge.
  task automatic resetPulse();
    reset = 1'b0;
    #1;
    clearModel();
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus();
  endtask

  initial begin
    int first_wr;
    int wr_seen;
    int n;

    vecs[0] = '{24'h0A141E, 8'h14};
    vecs[1] = '{24'hFFFFFF, 8'hFF};
    vecs[2] = '{24'h000000, 8'h00};
    vecs[3] = '{24'h010100, 8'h00};
    vecs[4] = '{24'h020101, 8'h01};
    vecs[5] = '{24'h808080, 8'h80};
    vecs[6] = '{24'hFF0000, 8'h55};
    vecs[7] = '{24'h00FF01, 8'h55};
    vecs[8] = '{24'hFFFE00, 8'hA9};

    // Reset state, with a non-empty input to prove the read is gated.
    reset         = 1'b0;
    fifo_in_empty = 1'b0;
    fifo_in_dout  = 24'h123456;
    fifo_out_full = 1'b0;
    #2;
    checkOutput("reset_rd_en", 32'(fifo_in_rd_en), 0);
    checkOutput("reset_wr_en", 32'(fifo_out_wr_en), 0);
    checkOutput("reset_din", 32'(fifo_out_din), 0);
    checkOutput("reset_frame_done", 32'(frame_done), 0);
    checkOutput("reset_frame_count", 32'(frame_count), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus();

    // Table of single pixels into an idle pipe: value and three-cycle latency.
    for (int i = 0; i < 9; i++) begin
      in_q.push_back(vecs[i].pix);
      applyStimulus();
      drain();
      checkOutput($sformatf("table_lum_%0d", i), 32'(last_din), 32'(vecs[i].lum));
      checkOutput($sformatf("table_latency_%0d", i), last_lat, 3);
    end

    // Backpressure: ten gray pixels, output full for five cycles after the
    // second write.
    for (int k = 1; k <= 10; k++) in_q.push_back({8'(k), 8'(k), 8'(k)});
    bp_mode   = 1'b1;
    bp_writes = 0;
    bp_left   = 5;
    applyStimulus();
    drain();
    bp_mode = 1'b0;
    checkOutput("bp_write_total", bp_writes, 10);
    checkOutput("bp_stall_used", bp_left, 0);

    // Reset with three pixels in flight.
    for (int k = 0; k < 5; k++) in_q.push_back(24'h300000 + 24'(k * 24'h010203));
    applyStimulus();
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checkOutput("midreset_rd_en", 32'(fifo_in_rd_en), 0);
    checkOutput("midreset_wr_en", 32'(fifo_out_wr_en), 0);
    checkOutput("midreset_din", 32'(fifo_out_din), 0);
    checkOutput("midreset_frame_count", 32'(frame_count), 0);
    clearModel();
    tick();
    reset = 1'b1;
    applyStimulus();
    drain();
    checkOutput("post_reset_latency", last_lat, 3);
    for (int k = 0; k < 6; k++) in_q.push_back(24'($urandom));
    applyStimulus();
    drain();
    checkOutput("post_reset_frames", 32'(frame_count), 1);

    // Frame boundary: 20 back-to-back pixels, writes must be gapless.
    resetPulse();
    for (int k = 0; k < 20; k++) in_q.push_back(24'($urandom));
    applyStimulus();
    first_wr = 0;
    wr_seen  = 0;
    n        = 0;
    while (wr_seen < 20 && n < 100) begin
      tick();
      n++;
      if (wrote_now) begin
        if (wr_seen == 0) first_wr = cyc;
        wr_seen++;
      end
    end
    checkOutput("frame_writes", wr_seen, 20);
    checkOutput("frame_gapless_span", cyc - first_wr, 19);
    tick();
    checkOutput("frame_count_two", 32'(frame_count), 2);

    // Random empty/full toggling over three frames.
    resetPulse();
    rand_mode = 1'b1;
    for (int k = 0; k < 3 * FRAME; k++) in_q.push_back(24'($urandom));
    applyStimulus();
    drain();
    rand_mode = 1'b0;
    applyStimulus();
    tick();
    checkOutput("random_frame_count", 32'(frame_count), 3);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
